// File: rtl/wrapper_pkg.sv
// Shared definitions for the input and output bus wrappers around the accelerator.
// Holds the wrapper FSM encoding and the byte/word widths.
package wrapper_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAITBYTE = 3'd2,
        S_ACCEPT   = 3'd3,
        S_START    = 3'd4,
        S_BUSY     = 3'd5
    } state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects two bytes into one word: the first byte goes high and the second goes low.
// A 1-bit counter selects the target byte; carry flags the accept that completes the word.
module word_assembler
    import wrapper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic              inc,
    input  logic [BYTE_W-1:0] din,
    output logic              carry,
    output logic [WORD_W-1:0] word
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (cap) begin
            if (!cnt_q) hi_d = din;
            else        lo_d = din;
        end
        // Clear has priority so an abandoned count never leaks into the next word.
        if (clr)      cnt_d = 1'b0;
        else if (inc) cnt_d = ~cnt_q;
    end

    assign carry = cnt_q & inc;
    assign word  = {hi_q, lo_q};

endmodule

// File: rtl/wrapper_input.sv
// Input-side bus wrapper: requests the shared bus, captures two bytes into a word
// and pulses start to the accelerator. Outputs are decoded from the state only.
module wrapper_input
    import wrapper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] inbus,
    input  logic              dvalid,
    input  logic              gnti,
    input  logic              accrdy,
    output logic              reqi,
    output logic              ibe,
    output logic              acc,
    output logic              start,
    output logic [WORD_W-1:0] x
);

    state_e state_q, state_d;
    logic   cap, inc, clr, carry;

    word_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .cap   (cap),
        .inc   (inc),
        .din   (inbus),
        .carry (carry),
        .word  (x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        reqi    = 1'b0;
        ibe     = 1'b0;
        acc     = 1'b0;
        start   = 1'b0;
        cap     = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr = 1'b1;
                if (accrdy) state_d = S_REQ;
            end
            S_REQ: begin
                reqi = 1'b1;
                if (gnti) state_d = S_WAITBYTE;
            end
            // gnti is no longer consulted: a granted transfer runs to completion.
            S_WAITBYTE: begin
                reqi = 1'b1;
                ibe  = 1'b1;
                if (dvalid) begin
                    cap     = 1'b1;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                acc     = 1'b1;
                reqi    = 1'b1;
                inc     = 1'b1;
                state_d = carry ? S_START : S_WAITBYTE;
            end
            S_START: begin
                start   = 1'b1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (!accrdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wrapper_input.sv
// Directed bench for wrapper_input: expected words are queued when bytes are driven
// and compared against x whenever the DUT pulses start.
module tb_wrapper_input;
    import wrapper_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inbus;
    logic        dvalid, gnti, accrdy;
    logic        reqi, ibe, acc, start;
    logic [15:0] x;

    int checks = 0;
    int fails  = 0;
    int acc_cnt = 0;
    int start_cnt = 0;
    int a0, s0;
    bit got;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    wrapper_input dut (
        .clk    (clk),
        .rst    (rst),
        .inbus  (inbus),
        .dvalid (dvalid),
        .gnti   (gnti),
        .accrdy (accrdy),
        .reqi   (reqi),
        .ibe    (ibe),
        .acc    (acc),
        .start  (start),
        .x      (x)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts pulses and scores each completed word on start.
    always @(negedge clk) begin
        if (acc) acc_cnt++;
        if (start) begin
            start_cnt++;
            check("acc_start_excl", {31'd0, acc}, 32'd0);
            if (exp_q.size() == 0) begin
                check("start_unexpected", 32'd1, 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("word_x", {16'd0, x}, {16'd0, exp_w});
                $display("word: x=%h expected=%h", x, exp_w);
            end
        end
    end

    task automatic wait_ibe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ibe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ibe_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        wait_ibe(ok);
        if (ok) begin
            inbus  = b;
            dvalid = 1'b1;
            @(posedge clk);
            #1 dvalid = 1'b0;
            @(negedge clk);
            check("acc_latency", {31'd0, acc}, 32'd1);
        end
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                             input int gap, input bit drop_gnt);
        exp_q.push_back({hi, lo});
        send_byte(hi);
        if (drop_gnt) gnti = 1'b0;
        repeat (gap) @(negedge clk);
        if (gap > 0) check("ibe_in_gap", {31'd0, ibe}, 32'd1);
        send_byte(lo);
        @(negedge clk);
        check("start_latency", {31'd0, start}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; inbus = 8'h00; dvalid = 1'b0; gnti = 1'b0; accrdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_reqi",  {31'd0, reqi},  32'd0);
        check("rst_ibe",   {31'd0, ibe},   32'd0);
        check("rst_acc",   {31'd0, acc},   32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_x",     {16'd0, x},     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'd0, reqi}, 32'd0);

        // Basic word with grant delayed two cycles.
        accrdy = 1'b1;
        repeat (2) @(negedge clk);
        check("req_pre_grant", {31'd0, reqi}, 32'd1);
        check("ibe_pre_grant", {31'd0, ibe},  32'd0);
        gnti = 1'b1;
        a0 = acc_cnt;
        send_word(8'hA5, 8'h3C, 0, 1'b0);
        check("acc_count_w1", acc_cnt - a0, 32'd2);
        accrdy = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_busy", {29'd0, dut.state_q}, {29'd0, S_IDLE});
        check("x_hold", {16'd0, x}, 32'h0000A53C);

        // Grant withheld for ten cycles.
        gnti = 1'b0; accrdy = 1'b1;
        repeat (10) @(negedge clk);
        check("nogrant_reqi", {31'd0, reqi}, 32'd1);
        check("nogrant_ibe",  {31'd0, ibe},  32'd0);
        check("nogrant_x",    {16'd0, x},    32'h0000A53C);

        // Gaps between bytes, grant dropped after the first byte.
        gnti = 1'b1;
        a0 = acc_cnt;
        send_word(8'h12, 8'h34, 3, 1'b1);
        check("acc_count_gap", acc_cnt - a0, 32'd2);
        accrdy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after the first byte discards the partial word.
        accrdy = 1'b1; gnti = 1'b1;
        send_byte(8'hFF);
        gnti = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_x",     {16'd0, x},    32'd0);
        check("midrst_reqi",  {31'd0, reqi}, 32'd0);
        check("midrst_state", {29'd0, dut.state_q}, {29'd0, S_IDLE});
        @(posedge clk);
        #1 rst = 1'b0;
        s0 = start_cnt;
        repeat (5) @(negedge clk);
        check("midrst_no_start", start_cnt - s0, 32'd0);
        gnti = 1'b1;
        send_word(8'h01, 8'h02, 0, 1'b0);

        // accrdy held high keeps the block parked in BUSY.
        repeat (5) @(negedge clk);
        check("busy_reqi",  {31'd0, reqi}, 32'd0);
        check("busy_state", {29'd0, dut.state_q}, {29'd0, S_BUSY});
        accrdy = 1'b0;
        @(negedge clk);
        accrdy = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (reqi) begin
                got = 1'b1;
                break;
            end
        end
        check("rerequest", {31'd0, got}, 32'd1);
        send_word(8'h5A, 8'h6B, 0, 1'b0);
        accrdy = 1'b0;
        repeat (2) @(negedge clk);

        // dvalid in IDLE and REQ must not capture.
        a0 = acc_cnt;
        inbus = 8'h77; dvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_dv_x", {16'd0, x}, 32'h00005A6B);
        gnti = 1'b0; accrdy = 1'b1;
        repeat (3) @(negedge clk);
        check("req_dv_state", {29'd0, dut.state_q}, {29'd0, S_REQ});
        check("req_dv_x",     {16'd0, x}, 32'h00005A6B);
        check("dv_no_acc",    acc_cnt - a0, 32'd0);
        dvalid = 1'b0; gnti = 1'b1;
        send_word(8'hC3, 8'h96, 1, 1'b0);
        accrdy = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/wrapper_input.md
WRAPPER_INPUT -- requirements
Module: wrapper_input

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 inbus  input  8  shared byte bus; sampled only when ibe=1 and dvalid=1.
REQ-005 dvalid  input  1  bus side: byte on inbus is valid this cycle.
REQ-006 gnti  input  1  bus grant for this block's input request.
REQ-007 accrdy  input  1  accelerator idle and able to take a new word.
REQ-008 reqi  output  1  request for the bus input channel.
REQ-009 ibe  output  1  input bus enable; high while waiting for a byte.
REQ-010 acc  output  1  one-cycle accept pulse per captured byte.
REQ-011 start  output  1  one-cycle pulse: x is valid, accelerator may begin.
REQ-012 x  output  16  assembled word: first byte in x[15:8], second byte in x[7:0].

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAITBYTE, ACCEPT, START and BUSY, encoded in 3 bits.
REQ-014 IDLE: all outputs low, byte counter cleared; next = accrdy ? REQ : IDLE.
REQ-015 REQ: reqi=1; next = gnti ? WAITBYTE : REQ.
REQ-016 WAITBYTE: reqi=1, ibe=1; on dvalid=1, capture inbus (cnt=0 -> high byte, cnt=1 -> low byte) at this clock edge and go to ACCEPT; otherwise stay.
REQ-017 Once granted, the block SHALL ignore gnti until the word completes; gnti deassertion SHALL NOT abort the transfer.
REQ-018 ACCEPT: acc=1, reqi=1, counter increments; next = (cnt==1) ? START : WAITBYTE.
REQ-019 START: start=1 for exactly one cycle; next = BUSY.
REQ-020 BUSY: all outputs low; next = accrdy ? BUSY : IDLE, so accrdy must drop before another word is requested.
REQ-021 x SHALL change only on a byte capture and SHALL hold its value from START until the next capture.
REQ-022 The block SHALL ignore dvalid in any state other than WAITBYTE.
REQ-023 The 1-bit byte counter SHALL wrap from 1 to 0 on the second accept; carry = cnt & increment.
REQ-024 Latency SHALL be: byte-2 capture edge -> acc on the next cycle -> start on the cycle after that.
REQ-025 Outputs SHALL be decoded from the state only (Moore); acc and start SHALL never be high at the same time.

Reset
REQ-026 When rst is asserted, state SHALL become IDLE; counter, high byte and low byte SHALL become 0; x SHALL become 16'h0000.
REQ-027 Reset values SHALL be reqi=0, ibe=0, acc=0, start=0.
REQ-028 Reset mid-transfer SHALL discard any partial word; no start pulse SHALL follow.

Structure
REQ-029 A shared package wrapper_pkg SHALL hold the state encodings, BYTE_W=8 and WORD_W=16, also used by the output wrapper.
REQ-030 A single sub-module word_assembler SHALL contain the two byte registers, the counter and the carry; the FSM SHALL stay in wrapper_input.

Verification
REQ-031 Scenario: accrdy=1, gnti=1 after 2 cycles, bytes 8'hA5 then 8'h3C with dvalid -> two acc pulses, one start, x=16'hA53C.
REQ-032 Scenario: gnti held low for 10 cycles -> reqi stays high, ibe=0, x unchanged.
REQ-033 Scenario: dvalid gaps of 3 cycles between bytes, gnti dropped after grant -> word 16'h1234 still assembled, acc count=2.
REQ-034 Scenario: rst asserted after first byte 8'hFF -> x=16'h0000, state IDLE, no start; next word 16'h0102 assembles correctly.
REQ-035 Scenario: accrdy kept high after start -> block stays in BUSY with reqi=0; accrdy low then high -> new request issued.
REQ-036 Scenario: dvalid pulsed in IDLE and REQ with inbus=8'h77 -> no capture, x unchanged.
